// File: rtl/rx_frame_sync_pkg.sv
// Shared definitions for the frame sync receiver and the matching Tx framer:
// FSM state encoding, default sync word and a 16-bit popcount.
package rx_frame_sync_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_VERIFY  = 2'd2
  } sync_state_t;

  localparam logic [15:0] DEFAULT_SYNC_WORD = 16'h1ACF;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + 5'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/sync_correlator.sv
// Combinational sync-word correlator: Hamming distance of the window to the
// sync word and to its complement, with threshold matches.
module sync_correlator
  import rx_frame_sync_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD = DEFAULT_SYNC_WORD,
  parameter int          MAX_ERR   = 1
) (
  input  logic [15:0] i_win,
  output logic [4:0]  o_d,
  output logic [4:0]  o_di,
  output logic        o_match,
  output logic        o_match_inv
);

  localparam logic [4:0] MAX_ERR_D = 5'(MAX_ERR);

  assign o_d         = popcount16(i_win ^ SYNC_WORD);
  assign o_di        = popcount16(i_win ^ ~SYNC_WORD);
  assign o_match     = (o_d <= MAX_ERR_D);
  assign o_match_inv = (o_di <= MAX_ERR_D);

endmodule

// File: rtl/rx_frame_sync.sv
// Frame synchroniser: hunts for the sync word in either polarity, then packs
// each frame's payload into bytes and flywheels through missed sync checks.
module rx_frame_sync
  import rx_frame_sync_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD   = DEFAULT_SYNC_WORD,
  parameter int          FRAME_BYTES = 16,
  parameter int          MAX_ERR     = 1,
  parameter int          MISS_LIMIT  = 3
) (
  input  logic        clk_16M384,
  input  logic        rst_16M384,
  input  logic        Rx_1bit,
  input  logic        Rx_valid,
  output logic [7:0]  data_tdata,
  output logic        data_tvalid,
  output logic        data_tuser,
  output logic        data_tlast,
  output logic        locked,
  output logic        inverted,
  output logic [15:0] frame_cnt
);

  localparam logic [10:0] LAST_BIT  = 11'(FRAME_BYTES * 8 - 1);
  localparam logic [4:0]  MAX_ERR_D = 5'(MAX_ERR);
  localparam logic [3:0]  MISS_LIM  = 4'(MISS_LIMIT);

  sync_state_t r_state;
  // Only 15 bits of history are stored; the 16th window bit is the incoming one.
  logic [14:0] r_win;
  logic [10:0] r_bit_cnt;
  logic [3:0]  r_miss;
  logic [7:0]  r_byte;
  logic [7:0]  r_tdata;
  logic        r_tvalid;
  logic        r_tuser;
  logic        r_tlast;
  logic        r_locked;
  logic        r_inverted;
  logic [15:0] r_frame_cnt;

  logic [15:0] w_win_next;
  logic [4:0]  w_d;
  logic [4:0]  w_di;
  logic        w_match;
  logic        w_match_inv;
  logic [7:0]  w_byte_next;
  logic [3:0]  w_miss_next;
  logic        w_verify_ok;

  assign w_win_next  = {r_win, Rx_1bit};
  assign w_byte_next = {r_byte[6:0], Rx_1bit ^ r_inverted};
  assign w_miss_next = r_miss + 4'd1;
  // Once locked, only the established polarity counts as a good sync.
  assign w_verify_ok = r_inverted ? (w_di <= MAX_ERR_D) : (w_d <= MAX_ERR_D);

  sync_correlator #(
    .SYNC_WORD (SYNC_WORD),
    .MAX_ERR   (MAX_ERR)
  ) u_corr (
    .i_win       (w_win_next),
    .o_d         (w_d),
    .o_di        (w_di),
    .o_match     (w_match),
    .o_match_inv (w_match_inv)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_16M384) begin
    if (rst_16M384) begin
      r_state     <= ST_HUNT;
      r_win       <= '0;
      r_bit_cnt   <= '0;
      r_miss      <= '0;
      r_byte      <= '0;
      r_tdata     <= '0;
      r_tvalid    <= 1'b0;
      r_tuser     <= 1'b0;
      r_tlast     <= 1'b0;
      r_locked    <= 1'b0;
      r_inverted  <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_tvalid <= 1'b0;
      if (Rx_valid) begin
        r_win <= w_win_next[14:0];
        unique case (r_state)
          ST_HUNT: begin
            r_locked  <= 1'b0;
            r_miss    <= '0;
            r_bit_cnt <= '0;
            if (w_match) begin
              r_inverted <= 1'b0;
              r_state    <= ST_PAYLOAD;
            end else if (w_match_inv) begin
              r_inverted <= 1'b1;
              r_state    <= ST_PAYLOAD;
            end
          end

          ST_PAYLOAD: begin
            r_byte <= w_byte_next;
            if (r_bit_cnt[2:0] == 3'd7) begin
              r_tvalid <= 1'b1;
              r_tdata  <= w_byte_next;
              r_tuser  <= (r_bit_cnt == 11'd7);
              r_tlast  <= (r_bit_cnt == LAST_BIT);
            end
            if (r_bit_cnt == LAST_BIT) begin
              r_frame_cnt <= r_frame_cnt + 16'd1;
              r_bit_cnt   <= '0;
              r_state     <= ST_VERIFY;
            end else begin
              r_bit_cnt <= r_bit_cnt + 11'd1;
            end
          end

          ST_VERIFY: begin
            if (r_bit_cnt == 11'd15) begin
              r_bit_cnt <= '0;
              if (w_verify_ok) begin
                r_locked <= 1'b1;
                r_miss   <= '0;
                r_state  <= ST_PAYLOAD;
              end else if (w_miss_next == MISS_LIM) begin
                r_locked   <= 1'b0;
                r_inverted <= 1'b0;
                r_miss     <= '0;
                r_state    <= ST_HUNT;
              end else begin
                r_miss  <= w_miss_next;
                r_state <= ST_PAYLOAD;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 11'd1;
            end
          end

          default: r_state <= ST_HUNT;
        endcase
      end
    end
  end

  assign data_tdata  = r_tdata;
  assign data_tvalid = r_tvalid;
  assign data_tuser  = r_tuser;
  assign data_tlast  = r_tlast;
  assign locked      = r_locked;
  assign inverted    = r_inverted;
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_rx_frame_sync.sv
// Directed bench for rx_frame_sync: acquisition in both polarities, error
// tolerance, flywheel/loss of lock, back-to-back strobes and mid-frame reset.
module tb_rx_frame_sync;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_bit = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tuser;
  logic        tlast;
  logic        lck;
  logic        inv;
  logic [15:0] fcnt;

  int errors = 0;
  int checks = 0;
  int gap = 16;
  int cycle = 0;

  logic [9:0] q[$];
  int         qt[$];

  rx_frame_sync dut (
    .clk_16M384  (clk),
    .rst_16M384  (rst),
    .Rx_1bit     (rx_bit),
    .Rx_valid    (rx_valid),
    .data_tdata  (tdata),
    .data_tvalid (tvalid),
    .data_tuser  (tuser),
    .data_tlast  (tlast),
    .locked      (lck),
    .inverted    (inv),
    .frame_cnt   (fcnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    if (tvalid) begin
      q.push_back({tuser, tlast, tdata});
      qt.push_back(cycle);
    end
  end

  task automatic send_bit(input logic b);
    rx_bit   = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (gap - 1) begin @(posedge clk); #1; end
  endtask

  task automatic send_word(input logic [15:0] w, input logic flip);
    for (int i = 15; i >= 0; i--) send_bit(w[i] ^ flip);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic flip);
    for (int i = 7; i >= 0; i--) send_bit(b[i] ^ flip);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    q.delete();
    qt.delete();
  endtask

  task automatic check_frame(input string tag, input int base);
    for (int i = 0; i < 16; i++) begin
      logic [9:0] exp;
      exp = {(i == 0), (i == 15), 8'(i)};
      checks++;
      if (base + i >= q.size()) begin
        $display("FAIL %s byte%0d: missing, required %h", tag, i, exp);
        errors++;
      end else if (q[base + i] !== exp) begin
        $display("FAIL %s byte%0d: got user/last/data %h required %h", tag, i, q[base + i], exp);
        errors++;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({tdata, tvalid, tuser, tlast} !== 11'd0) begin
      $display("FAIL reset_outputs: got %h required 0", {tdata, tvalid, tuser, tlast});
      errors++;
    end
    checks++;
    if ({lck, inv, fcnt} !== 18'd0) begin
      $display("FAIL reset_status: got %h required 0", {lck, inv, fcnt});
      errors++;
    end
  endtask

  task automatic test_acquire(input string tag, input logic flip);
    do_reset();
    gap = 16;
    send_word(16'h1ACF, flip);
    checks++;
    if (lck !== 1'b0 || inv !== flip) begin
      $display("FAIL %s_first_sync: got locked=%b inverted=%b required 0/%b", tag, lck, inv, flip);
      errors++;
    end
    for (int i = 0; i < 16; i++) send_byte(8'(i), flip);
    send_word(16'h1ACF, flip);
    checks++;
    if (q.size() !== 16) begin
      $display("FAIL %s_count: got %0d bytes required 16", tag, q.size());
      errors++;
    end
    check_frame(tag, 0);
    checks++;
    if (fcnt !== 16'd1 || lck !== 1'b1 || inv !== flip) begin
      $display("FAIL %s_status: got cnt=%0d locked=%b inv=%b required 1/1/%b", tag, fcnt, lck, inv, flip);
      errors++;
    end
  endtask

  task automatic test_error_tolerance();
    do_reset();
    gap = 2;
    send_word(16'h1ACF ^ 16'h0100, 1'b0);
    send_byte(8'hA5, 1'b0);
    checks++;
    if (q.size() !== 1 || (q.size() == 1 && q[0] !== {2'b10, 8'hA5})) begin
      $display("FAIL err1_accept: got %0d bytes first %h required 1 byte 2a5", q.size(), (q.size() > 0) ? q[0] : 10'h0);
      errors++;
    end
    do_reset();
    send_word(16'h1ACF ^ 16'h0101, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    checks++;
    if (q.size() !== 0 || lck !== 1'b0) begin
      $display("FAIL err2_reject: got %0d bytes locked=%b required 0/0", q.size(), lck);
      errors++;
    end
    send_word(16'h1ACF, 1'b0);
    send_byte(8'h3C, 1'b0);
    checks++;
    if (q.size() !== 1 || (q.size() == 1 && q[0] !== {2'b10, 8'h3C})) begin
      $display("FAIL err2_still_hunting: got %0d bytes required 1 byte 23c", q.size());
      errors++;
    end
  endtask

  task automatic test_flywheel();
    do_reset();
    gap = 2;
    send_word(16'h1ACF, 1'b0);
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0);
    send_word(16'h1ACF, 1'b0);
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0);
      if (f < 2) send_word(16'h1ACF ^ 16'h0007, 1'b0);
    end
    checks++;
    if (lck !== 1'b1 || fcnt !== 16'd4 || q.size() !== 64) begin
      $display("FAIL fly_hold: got locked=%b cnt=%0d bytes=%0d required 1/4/64", lck, fcnt, q.size());
      errors++;
    end
    check_frame("fly_f4", 48);
    send_word(16'h1ACF ^ 16'h0007, 1'b0);
    checks++;
    if (lck !== 1'b0 || inv !== 1'b0) begin
      $display("FAIL fly_loss: got locked=%b inv=%b required 0/0", lck, inv);
      errors++;
    end
    for (int i = 0; i < 16; i++) send_byte(8'h00, 1'b0);
    checks++;
    if (q.size() !== 64) begin
      $display("FAIL fly_quiet: got %0d bytes required 64", q.size());
      errors++;
    end
    send_word(16'h1ACF, 1'b0);
    send_byte(8'h5A, 1'b0);
    checks++;
    if (q.size() !== 65 || (q.size() == 65 && q[64] !== {2'b10, 8'h5A})) begin
      $display("FAIL fly_reacquire: got %0d bytes required 65 ending 25a", q.size());
      errors++;
    end
  endtask

  task automatic test_back_to_back();
    logic seen_last;
    do_reset();
    gap = 1;
    send_word(16'h1ACF, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(8'(i), 1'b0);
    for (int i = 7; i >= 4; i--) send_bit(1'b1);
    checks++;
    if (q.size() !== 4) begin
      $display("FAIL b2b_count: got %0d bytes required 4", q.size());
      errors++;
    end
    for (int i = 1; i < 4 && i < qt.size(); i++) begin
      checks++;
      if (qt[i] - qt[i-1] !== 8) begin
        $display("FAIL b2b_spacing%0d: got %0d cycles required 8", i, qt[i] - qt[i-1]);
        errors++;
      end
    end
    // Reset lands in the middle of byte 5 while strobes keep arriving.
    rst = 1'b1;
    rx_bit = 1'b1;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({tdata, tvalid, tuser, tlast, lck, inv, fcnt} !== 29'd0) begin
      $display("FAIL b2b_mid_reset: got %h required 0", {tdata, tvalid, tuser, tlast, lck, inv, fcnt});
      errors++;
    end
    rx_valid = 1'b0;
    rst = 1'b0;
    seen_last = 1'b0;
    foreach (q[i]) if (q[i][8]) seen_last = 1'b1;
    checks++;
    if (seen_last !== 1'b0) begin
      $display("FAIL b2b_no_tlast: got tlast seen=%b required 0", seen_last);
      errors++;
    end
    q.delete();
    qt.delete();
    send_word(16'h1ACF, 1'b0);
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0);
    send_word(16'h1ACF, 1'b0);
    check_frame("b2b_resync", 0);
    checks++;
    if (fcnt !== 16'd1 || lck !== 1'b1) begin
      $display("FAIL b2b_restart: got cnt=%0d locked=%b required 1/1", fcnt, lck);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_acquire("clean", 1'b0);
    test_acquire("inverted", 1'b1);
    test_error_tolerance();
    test_flywheel();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
